// File: rtl/drop_sequencer.sv
// Per-piece game-flow controller: sequences drop, lock delay, lock, line clear and spawn
// over req/ack handshakes, and tracks cleared lines and the level fed to the gravity divider.
module drop_sequencer #(
   parameter int unsigned LOCK_DELAY      = 25000000,
   parameter int unsigned MAX_LOCK_RESETS = 15,
   parameter int unsigned LINES_PER_LEVEL = 10,
   parameter int unsigned MAX_LEVEL       = 7
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        start,
   input  logic        piece_clk,
   input  logic        hard_drop,
   input  logic        shift_done,
   output logic        down_req,
   input  logic        down_ack,
   input  logic        down_blocked,
   output logic        lock_req,
   input  logic        clear_done,
   input  logic [2:0]  lines_cleared,
   output logic        spawn_req,
   input  logic        spawn_ack,
   input  logic        spawn_fail,
   output logic [2:0]  level,
   output logic [15:0] lines_total,
   output logic        game_over
);

   localparam int unsigned CntW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
   localparam int unsigned RcW  = (MAX_LOCK_RESETS > 0) ? $clog2(MAX_LOCK_RESETS + 1) : 1;
   localparam int unsigned RemW = $clog2(LINES_PER_LEVEL + 4);

   localparam logic [CntW-1:0] LockLast    = CntW'(LOCK_DELAY - 1);
   localparam logic [RcW-1:0]  ResetsMax   = RcW'(MAX_LOCK_RESETS);
   localparam logic [RemW-1:0] LinesPerLvl = RemW'(LINES_PER_LEVEL);
   localparam logic [2:0]      LevelMax    = 3'(MAX_LEVEL);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StSpawn    = 3'd1;
   localparam logic [2:0] StFall     = 3'd2;
   localparam logic [2:0] StDropWait = 3'd3;
   localparam logic [2:0] StLockWait = 3'd4;
   localparam logic [2:0] StLock     = 3'd5;
   localparam logic [2:0] StClear    = 3'd6;
   localparam logic [2:0] StOver     = 3'd7;

   logic [2:0]      state_q, state_d;
   logic            hd_q, hd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [RcW-1:0]  rc_q, rc_d;
   logic [2:0]      level_q, level_d;
   logic [15:0]     total_q, total_d;
   logic [RemW-1:0] rem_q, rem_d;
   logic            down_req_q, down_req_d;
   logic            spawn_req_q, spawn_req_d;
   logic            lock_req_q, lock_req_d;
   logic            game_over_q, game_over_d;

   logic            down_fire;
   logic            spawn_fire;
   logic            clear_fire;
   logic            new_game;
   logic            shift_ok;
   logic [16:0]     lines_sum;
   logic [RemW-1:0] rem_sum;

   // An ack only counts while the matching request is actually outstanding.
   assign down_fire  = (state_q == StDropWait) && down_req_q && down_ack;
   assign spawn_fire = (state_q == StSpawn) && spawn_req_q && spawn_ack;
   assign clear_fire = (state_q == StClear) && clear_done;
   assign new_game   = ((state_q == StIdle) || (state_q == StOver)) && start;
   assign shift_ok   = shift_done && (rc_q < ResetsMax);

   assign lines_sum = {1'b0, total_q} + {14'd0, lines_cleared};
   assign rem_sum   = rem_q + RemW'(lines_cleared);

   always_comb begin
      state_d = state_q;
      hd_d    = hd_q;
      cnt_d   = cnt_q;
      rc_d    = rc_q;
      case (state_q)
         StIdle: begin
            if (new_game) begin
               state_d = StSpawn;
            end
         end
         StSpawn: begin
            if (spawn_fire) begin
               if (spawn_fail) begin
                  state_d = StOver;
               end else begin
                  state_d = StFall;
                  rc_d    = '0;
                  hd_d    = 1'b0;
               end
            end
         end
         StFall: begin
            if (hard_drop) begin
               hd_d    = 1'b1;
               state_d = StDropWait;
            end else if (piece_clk) begin
               state_d = StDropWait;
            end
         end
         StDropWait: begin
            if (down_fire) begin
               if (!down_blocked) begin
                  // A hard drop keeps stepping down until the board reports a collision.
                  if (!hd_q) begin
                     state_d = StFall;
                     cnt_d   = '0;
                  end
               end else if (hd_q) begin
                  state_d = StLock;
               end else begin
                  state_d = StLockWait;
                  cnt_d   = '0;
               end
            end
         end
         StLockWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (hard_drop) begin
               state_d = StLock;
            end else if (cnt_q == LockLast) begin
               state_d = StLock;
            end else if (piece_clk) begin
               state_d = StDropWait;
               hd_d    = 1'b0;
            end else if (shift_ok) begin
               cnt_d = '0;
               rc_d  = rc_q + RcW'(1);
            end
         end
         StLock: begin
            state_d = StClear;
         end
         StClear: begin
            if (clear_fire) begin
               state_d = StSpawn;
            end
         end
         StOver: begin
            if (new_game) begin
               state_d = StSpawn;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Score keeping: saturating line total, level advances on each remainder wrap.
   always_comb begin
      level_d = level_q;
      total_d = total_q;
      rem_d   = rem_q;
      if (new_game) begin
         level_d = '0;
         total_d = '0;
         rem_d   = '0;
      end else if (clear_fire) begin
         total_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
         if (rem_sum >= LinesPerLvl) begin
            rem_d = rem_sum - LinesPerLvl;
            if (level_q < LevelMax) begin
               level_d = level_q + 3'd1;
            end
         end else begin
            rem_d = rem_sum;
         end
      end
   end

   // down_req drops for the cycle after an accepted ack even when staying in DROP_WAIT.
   always_comb begin
      down_req_d  = (state_d == StDropWait) && !down_fire;
      spawn_req_d = (state_d == StSpawn);
      lock_req_d  = (state_d == StLock);
      game_over_d = (state_d == StOver);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         hd_q        <= 1'b0;
         cnt_q       <= '0;
         rc_q        <= '0;
         level_q     <= '0;
         total_q     <= '0;
         rem_q       <= '0;
         down_req_q  <= 1'b0;
         spawn_req_q <= 1'b0;
         lock_req_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hd_q        <= hd_d;
         cnt_q       <= cnt_d;
         rc_q        <= rc_d;
         level_q     <= level_d;
         total_q     <= total_d;
         rem_q       <= rem_d;
         down_req_q  <= down_req_d;
         spawn_req_q <= spawn_req_d;
         lock_req_q  <= lock_req_d;
         game_over_q <= game_over_d;
      end
   end

   assign down_req    = down_req_q;
   assign spawn_req   = spawn_req_q;
   assign lock_req    = lock_req_q;
   assign game_over   = game_over_q;
   assign level       = level_q;
   assign lines_total = total_q;

   a_one_request: assert property (@(posedge CLK) disable iff (!RESET_N)
      $onehot0({down_req_q, spawn_req_q, lock_req_q}));

   a_lock_pulse: assert property (@(posedge CLK) disable iff (!RESET_N)
      lock_req_q |=> !lock_req_q);

endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer: directed scenarios plus random play, checked every cycle
// against a deadline-based behavioural model of the game flow.
module tb_drop_sequencer;

   localparam int LD   = 20;
   localparam int MLR  = 15;
   localparam int LPL  = 10;
   localparam int MAXL = 7;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        start = 1'b0, piece_clk = 1'b0, hard_drop = 1'b0, shift_done = 1'b0;
   logic        down_ack = 1'b0, down_blocked = 1'b0, clear_done = 1'b0;
   logic [2:0]  lines_cleared = 3'd0;
   logic        spawn_ack = 1'b0, spawn_fail = 1'b0;
   logic        down_req, lock_req, spawn_req, game_over;
   logic [2:0]  level;
   logic [15:0] lines_total;

   drop_sequencer #(
      .LOCK_DELAY      (LD),
      .MAX_LOCK_RESETS (MLR),
      .LINES_PER_LEVEL (LPL),
      .MAX_LEVEL       (MAXL)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .start         (start),
      .piece_clk     (piece_clk),
      .hard_drop     (hard_drop),
      .shift_done    (shift_done),
      .down_req      (down_req),
      .down_ack      (down_ack),
      .down_blocked  (down_blocked),
      .lock_req      (lock_req),
      .clear_done    (clear_done),
      .lines_cleared (lines_cleared),
      .spawn_req     (spawn_req),
      .spawn_ack     (spawn_ack),
      .spawn_fail    (spawn_fail),
      .level         (level),
      .lines_total   (lines_total),
      .game_over     (game_over)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
   endtask

   // Model: game phase, lock expiry as an absolute edge deadline, total lines as a plain int.
   typedef enum int {MIdle, MSpawn, MFall, MDrop, MLockWait, MLock, MClear, MOver} mph_e;
   mph_e m_ph;
   bit   m_hd, m_gap;
   int   m_deadline, m_resets, m_lines, m_edges;

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_ph <= MIdle; m_hd <= 1'b0; m_gap <= 1'b0;
         m_deadline <= 0; m_resets <= 0; m_lines <= 0; m_edges <= 0;
      end else begin
         m_edges <= m_edges + 1;
         case (m_ph)
            MIdle, MOver: if (start) begin m_lines <= 0; m_ph <= MSpawn; end
            MSpawn: if (spawn_ack) begin
               if (spawn_fail) m_ph <= MOver;
               else begin m_ph <= MFall; m_resets <= 0; m_hd <= 1'b0; end
            end
            MFall: if (hard_drop) begin
               m_hd <= 1'b1; m_gap <= 1'b0; m_ph <= MDrop;
            end else if (piece_clk) begin
               m_gap <= 1'b0; m_ph <= MDrop;
            end
            MDrop: if (m_gap) m_gap <= 1'b0;
            else if (down_ack) begin
               if (!down_blocked) begin
                  if (m_hd) m_gap <= 1'b1;
                  else m_ph <= MFall;
               end else if (m_hd) m_ph <= MLock;
               else begin m_ph <= MLockWait; m_deadline <= m_edges + LD; end
            end
            MLockWait: if (hard_drop || m_edges == m_deadline) m_ph <= MLock;
            else if (piece_clk) begin m_ph <= MDrop; m_gap <= 1'b0; m_hd <= 1'b0; end
            else if (shift_done && m_resets < MLR) begin
               m_resets <= m_resets + 1; m_deadline <= m_edges + LD;
            end
            MLock: m_ph <= MClear;
            MClear: if (clear_done) begin
               m_lines <= m_lines + int'(lines_cleared); m_ph <= MSpawn;
            end
            default: m_ph <= MIdle;
         endcase
      end
   end

   logic e_down, e_spawn, e_lock, e_over;
   int   e_level, e_total;
   assign e_down  = (m_ph == MDrop) && !m_gap;
   assign e_spawn = (m_ph == MSpawn);
   assign e_lock  = (m_ph == MLock);
   assign e_over  = (m_ph == MOver);
   assign e_level = (m_lines / LPL > MAXL) ? MAXL : m_lines / LPL;
   assign e_total = (m_lines > 65535) ? 65535 : m_lines;

   bit chk_en = 1'b0;
   int down_rises = 0;
   bit down_prev = 1'b0;

   always @(negedge CLK) begin
      if (chk_en) begin
         check("down_req", down_req, e_down);
         check("spawn_req", spawn_req, e_spawn);
         check("lock_req", lock_req, e_lock);
         check("game_over", game_over, e_over);
         check("level", level, e_level);
         check("lines_total", lines_total, e_total);
      end
      if (down_req && !down_prev) down_rises++;
      down_prev = down_req;
   end

   task automatic tick();
      @(negedge CLK);
      #1;
      start = 0; piece_clk = 0; hard_drop = 0; shift_done = 0;
      down_ack = 0; down_blocked = 0; clear_done = 0; lines_cleared = 0;
      spawn_ack = 0; spawn_fail = 0;
   endtask

   task automatic wait_phase(input string name, input mph_e target, input int budget);
      for (int i = 0; i < budget && m_ph != target; i++) tick();
      check({"reach_", name}, int'(m_ph), int'(target));
   endtask

   task automatic wait_down(input int budget);
      for (int i = 0; i < budget && !e_down; i++) tick();
      check("down_req_seen", down_req, 1);
   endtask

   task automatic play_piece(input int lines);
      wait_phase("spawn", MSpawn, 20);
      spawn_ack = 1; tick();
      hard_drop = 1; tick();
      wait_down(10);
      down_ack = 1; down_blocked = 1; tick();
      wait_phase("clear", MClear, 10);
      clear_done = 1; lines_cleared = 3'(lines); tick();
   endtask

   int k, t15, tlock, shifts, base;
   bit got;

   initial begin
      tick(); tick();
      chk_en = 1'b1;
      check("rst_down_req", down_req, 0);
      check("rst_spawn_req", spawn_req, 0);
      check("rst_lock_req", lock_req, 0);
      check("rst_game_over", game_over, 0);
      check("rst_level", level, 0);
      check("rst_lines_total", lines_total, 0);
      RESET_N = 1'b1;
      tick();

      // Gravity drops, then a grounded piece waits out the full lock delay.
      start = 1; tick();
      check("start_spawn_req", spawn_req, 1);
      spawn_ack = 1; tick();
      check("fall_no_req", {down_req, spawn_req, lock_req}, 0);
      for (int i = 0; i < 4; i++) begin
         piece_clk = 1; tick();
         wait_down(10);
         repeat ($urandom_range(0, 3)) tick();
         down_ack = 1; down_blocked = (i == 3); tick();
      end
      k = 0;
      while (!lock_req && k < LD + 10) begin tick(); k++; end
      check("lock_delay_cycles", k, LD);
      tick();
      check("lock_pulse_width", lock_req, 0);
      clear_done = 1; lines_cleared = 0; tick();
      check("spawn_after_clear", spawn_req, 1);

      // Hard drop (coinciding with a gravity tick) runs 6 drop attempts then locks.
      spawn_ack = 1; tick();
      base = down_rises;
      hard_drop = 1; piece_clk = 1; tick();
      for (int p = 0; p < 6; p++) begin
         wait_down(10);
         down_ack = 1; down_blocked = (p == 5); tick();
      end
      check("hd_down_pulses", down_rises - base, 6);
      check("hd_lock_req", lock_req, 1);
      tick();
      clear_done = 1; tick();

      // Shifts every LD/2 cycles: only the first MLR restart the timer.
      spawn_ack = 1; tick();
      piece_clk = 1; tick();
      wait_down(10);
      down_ack = 1; down_blocked = 1; tick();
      got = 0; shifts = 0; t15 = -1000; tlock = -1;
      for (int i = 1; i <= 400 && !got; i++) begin
         if (i % (LD / 2) == 0 && shifts < 20) begin
            shift_done = 1; shifts++;
            if (shifts == MLR) t15 = i;
         end
         tick();
         if (lock_req) begin got = 1; tlock = i; end
      end
      check("shift_lock_delay", tlock - t15, LD);
      tick();
      clear_done = 1; tick();

      // Line accounting and level saturation.
      for (int p = 1; p <= 22; p++) begin
         play_piece(4);
         if (p == 3) begin
            check("lines_12", lines_total, 12);
            check("level_at_12", level, 1);
         end
         if (p == 4) check("level_at_16", level, 1);
         if (p == 5) check("level_at_20", level, 2);
         if (p == 20) begin
            check("lines_80", lines_total, 80);
            check("level_at_80", level, 7);
         end
         if (p == 22) check("level_at_88", level, 7);
      end

      // Spawn failure ends the game; stray inputs are ignored until start.
      wait_phase("spawn_fail", MSpawn, 20);
      spawn_ack = 1; spawn_fail = 1; tick();
      check("over_flag", game_over, 1);
      check("over_no_req", {down_req, spawn_req, lock_req}, 0);
      repeat (6) begin
         piece_clk = 1; hard_drop = 1; down_ack = 1; clear_done = 1; lines_cleared = 4;
         spawn_ack = 1; shift_done = 1; tick();
      end
      check("over_level_held", level, 7);
      check("over_lines_held", lines_total, 88);
      start = 1; tick();
      check("restart_over", game_over, 0);
      check("restart_level", level, 0);
      check("restart_lines", lines_total, 0);
      check("restart_spawn_req", spawn_req, 1);

      // Reset in the middle of a drop handshake.
      spawn_ack = 1; tick();
      piece_clk = 1; tick();
      wait_down(10);
      #1 RESET_N = 1'b0;
      #1 check("async_down_req", down_req, 0);
      repeat (3) begin down_ack = 1; tick(); end
      check("rst_ack_ignored", {down_req, spawn_req, lock_req, game_over}, 0);
      RESET_N = 1'b1;
      tick();

      // Random play.
      start = 1; tick();
      for (int i = 0; i < 4000; i++) begin
         start      = ($urandom_range(0, 99) < ((m_ph == MIdle || m_ph == MOver) ? 20 : 2));
         piece_clk  = ($urandom_range(0, 99) < 15);
         hard_drop  = ($urandom_range(0, 99) < 4);
         shift_done = ($urandom_range(0, 99) < 15);
         if (e_down) begin
            down_ack = ($urandom_range(0, 99) < 40);
            down_blocked = 1'($urandom_range(0, 1));
         end else if (m_ph != MDrop) begin
            down_ack = ($urandom_range(0, 99) < 3);
            down_blocked = 1'($urandom_range(0, 1));
         end
         spawn_ack  = ($urandom_range(0, 99) < ((m_ph == MSpawn) ? 50 : 3));
         spawn_fail = ($urandom_range(0, 99) < 8);
         clear_done = ($urandom_range(0, 99) < ((m_ph == MClear) ? 50 : 3));
         lines_cleared = 3'($urandom_range(0, 4));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
